// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan controller and the
// per-digit cathode driver: digit code type, blank code, width helpers.
package seven_seg_pkg;

    // 4-bit digit code presented to the cathode driver (BCD, 10..15 blank)
    typedef logic [3:0] digit_t;

    // Code the driver renders as an unlit digit
    localparam digit_t BLANK_CODE = 4'hF;

    // Ceiling log2; returns 0 for v <= 1
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // Ceiling log2 clamped to at least one bit, for register widths
    function automatic int clog2_min1(input int v);
        return (clog2(v) < 1) ? 1 : clog2(v);
    endfunction

    // Larger of two integers
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Slot/frame timing for the display scan. A slot counter runs
// 0..SLOT_CYCLES-1; at its last count the digit index advances, and
// the edge where the index wraps to 0 is the frame boundary.
module scan_tick_gen
    import seven_seg_pkg::*;
#(
    parameter int SLOT_CYCLES = 10,
    parameter int NUM_DIGITS  = 4,
    localparam int CNT_W      = clog2_min1(SLOT_CYCLES),
    localparam int IDX_W      = clog2_min1(NUM_DIGITS)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_slot_end,
    output logic             o_frame_end
);

    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             w_slot_end;
    logic             w_frame_end;

    assign w_slot_end  = (r_cnt == CNT_W'(SLOT_CYCLES - 1));
    assign w_frame_end = w_slot_end && (r_idx == IDX_W'(NUM_DIGITS - 1));

    // Slot counter and digit index; both wrap exactly at their last value
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            if (w_slot_end) begin
                r_cnt <= '0;
                if (w_frame_end) begin
                    r_idx <= '0;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_idx       = r_idx;
    assign o_slot_end  = w_slot_end;
    assign o_frame_end = w_frame_end;

endmodule

// File: rtl/seven_segment_scan_ctrl.sv
// Multiplexed scan controller for an N-digit common-anode seven-segment
// display. A staged frame (value/dots) is committed to the displayed
// shadow frame only at a frame boundary, so frames never tear. The
// current slot's digit/dot go to the downstream cathode driver (one
// registered stage); anode strobes are delayed one extra cycle so they
// switch on the same edge as the driver's cathode outputs.
//
// Build option SEVEN_SEG_SCAN_BLANK_EN: when defined, anodes are held
// off for the first 2 cycles of every slot as ghosting dead-time
// (requires SLOT_CYCLES >= 4). Digit/dot timing is identical either way.
module seven_segment_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int FRAME_HZ    = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dots,
    output logic                    commit,
    output logic [3:0]              digit,
    output logic                    dot_en,
    output logic [NUM_DIGITS-1:0]   anode_n
);

    localparam int SLOT_CYCLES = max_int(1, CLK_FREQ_HZ / (FRAME_HZ * NUM_DIGITS));
    localparam int IDX_W       = clog2_min1(NUM_DIGITS);

`ifdef SEVEN_SEG_SCAN_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
    if (SLOT_CYCLES < 4) begin : g_bad_slot_cycles
        $error("seven_segment_scan_ctrl: dead-time blanking needs SLOT_CYCLES >= 4");
    end
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    if (NUM_DIGITS < 2) begin : g_bad_num_digits
        $error("seven_segment_scan_ctrl: NUM_DIGITS must be at least 2");
    end

    logic [IDX_W-1:0]      w_idx;
    logic                  w_slot_end;
    logic                  w_frame_end;
    logic                  w_do_commit;
    logic [NUM_DIGITS-1:0] w_anode_sel_n;
    logic                  w_slot_early;

    digit_t                r_stage      [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] r_stage_dots;
    logic                  r_pending;
    digit_t                r_shadow     [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] r_shadow_dots;
    logic                  r_commit;

    logic [1:0]            r_slot_age;
    logic                  r_early_p1;
    digit_t                r_digit_p1;
    logic                  r_dot_en_p1;
    logic [NUM_DIGITS-1:0] r_anode_n_p1;
    logic [NUM_DIGITS-1:0] r_anode_n_p2;

    scan_tick_gen #(
        .SLOT_CYCLES (SLOT_CYCLES),
        .NUM_DIGITS  (NUM_DIGITS)
    ) u_tick (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .o_idx       (w_idx),
        .o_slot_end  (w_slot_end),
        .o_frame_end (w_frame_end)
    );

    // A boundary only transfers data when something was staged
    assign w_do_commit = w_frame_end && r_pending;

    // Staging captures loads; shadow takes staging at a pending boundary.
    // A load on the commit edge lands in staging after the old contents
    // moved to shadow, so pending stays set for the next boundary.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_stage[i]  <= BLANK_CODE;
                r_shadow[i] <= BLANK_CODE;
            end
            r_stage_dots  <= '0;
            r_shadow_dots <= '0;
            r_pending     <= 1'b0;
            r_commit      <= 1'b0;
        end else begin
            r_commit <= w_do_commit;
            if (w_do_commit) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    r_shadow[i] <= r_stage[i];
                end
                r_shadow_dots <= r_stage_dots;
            end
            if (load) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    r_stage[i] <= digit_t'(value[4*i +: 4]);
                end
                r_stage_dots <= dots;
                r_pending    <= 1'b1;
            end else if (w_frame_end) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Saturating age of the current slot (tracks the slot count up to 3)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_slot_age <= 2'd0;
        end else if (w_slot_end) begin
            r_slot_age <= 2'd0;
        end else if (r_slot_age != 2'd3) begin
            r_slot_age <= r_slot_age + 2'd1;
        end
    end

    assign w_slot_early = (r_slot_age < 2'd2);

    // Decode the active digit index into an active-low anode pattern
    always_comb begin
        w_anode_sel_n = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_idx == IDX_W'(k)) begin
                w_anode_sel_n[k] = 1'b0;
            end
        end
    end

    // ---- stage p1: digit/dot to the driver, anode pattern held one cycle
    // ---- stage p2: anodes switch with the driver's registered cathodes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_digit_p1   <= BLANK_CODE;
            r_dot_en_p1  <= 1'b0;
            r_anode_n_p1 <= '1;
            r_early_p1   <= 1'b0;
            r_anode_n_p2 <= '1;
        end else begin
            r_digit_p1   <= r_shadow[w_idx];
            r_dot_en_p1  <= r_shadow_dots[w_idx];
            r_anode_n_p1 <= w_anode_sel_n;
            r_early_p1   <= w_slot_early;
            r_anode_n_p2 <= (BLANK_EN && r_early_p1) ? '1 : r_anode_n_p1;
        end
    end

    assign commit  = r_commit;
    assign digit   = r_digit_p1;
    assign dot_en  = r_dot_en_p1;
    assign anode_n = r_anode_n_p2;

endmodule
